// File: rtl/instr_encoder.sv
// instr_encoder: assembles RV32I machine words from class/field requests and
// writes them sequentially into instruction memory through a write/ack port.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cls,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_CLASS = 2'b01;
  localparam logic [1:0] E_ALIGN = 2'b10;
  localparam logic [1:0] E_RANGE = 2'b11;

  typedef enum logic [0:0] {S_IDLE, S_WRITE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_we, w_we_nxt;
  logic [31:0]        r_addr, w_addr_nxt;
  logic [31:0]        r_wdata, w_wdata_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic               r_err, w_err_nxt;
  logic [1:0]         r_ecode, w_ecode_nxt;
  logic               r_busy, w_busy_nxt;

  logic [31:0]        w_word;
  logic [1:0]         w_ecode;
  logic               w_fit12, w_fit13, w_fit21, w_shamt_ok, w_is_shift;
  logic [6:0]         w_f7;

  // Immediate range predicates: upper bits must be a sign extension.
  always_comb begin
    w_fit12    = (imm[31:11] == {21{imm[11]}});
    w_fit13    = (imm[31:12] == {20{imm[12]}});
    w_fit21    = (imm[31:20] == {12{imm[20]}});
    w_shamt_ok = (imm[31:5] == 27'd0);
    w_is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    w_f7       = {1'b0, funct7b5, 5'b00000};
  end

  // Combinational encoder: machine word plus the error it would raise.
  always_comb begin
    w_word  = 32'd0;
    w_ecode = E_NONE;
    case (cls)
      4'd0: begin
        w_word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        if (!w_fit12) w_ecode = E_RANGE;
      end
      4'd1: begin
        w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        if (!w_fit12) w_ecode = E_RANGE;
      end
      4'd2: begin
        w_word = {w_f7, rs2, rs1, funct3, rd, OP_R};
      end
      4'd3: begin
        w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        if (imm[0])        w_ecode = E_ALIGN;
        else if (!w_fit13) w_ecode = E_RANGE;
      end
      4'd4: begin
        if (w_is_shift) begin
          w_word = {w_f7, imm[4:0], rs1, funct3, rd, OP_IALU};
          if (!w_shamt_ok) w_ecode = E_RANGE;
        end else begin
          w_word = {imm[11:0], rs1, funct3, rd, OP_IALU};
          if (!w_fit12) w_ecode = E_RANGE;
        end
      end
      4'd5: begin
        w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        if (imm[0])        w_ecode = E_ALIGN;
        else if (!w_fit21) w_ecode = E_RANGE;
      end
      4'd6: w_word = {imm[31:12], rd, OP_AUIPC};
      4'd7: w_word = {imm[31:12], rd, OP_LUI};
      4'd8: begin
        w_word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        if (!w_fit12) w_ecode = E_RANGE;
      end
      default: w_ecode = E_CLASS;
    endcase
  end

  // Next-state and next-output logic for the IDLE/WRITE controller.
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    w_ecode_nxt = r_ecode;
    in_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = !start;
        if (start) begin
          w_addr_nxt  = BASE_ADDR;
          w_count_nxt = '0;
          w_err_nxt   = 1'b0;
          w_ecode_nxt = E_NONE;
        end else if (in_valid) begin
          if (w_ecode == E_NONE) begin
            w_wdata_nxt = w_word;
            w_we_nxt    = 1'b1;
            w_state_nxt = S_WRITE;
          end else begin
            w_err_nxt = 1'b1;
            if (!r_err) w_ecode_nxt = w_ecode;
          end
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          w_we_nxt    = 1'b0;
          w_addr_nxt  = r_addr + 32'd4;
          if (r_count != {CNT_W{1'b1}}) w_count_nxt = r_count + CNT_W'(1);
          w_state_nxt = S_IDLE;
        end
      end
    endcase
    w_busy_nxt = (w_state_nxt == S_WRITE);
  end

  // State and output registers; reset drops the write strobe immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_wdata <= 32'd0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_ecode <= E_NONE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      r_ecode <= w_ecode_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign err       = r_err;
  assign err_code  = r_ecode;
  assign busy      = r_busy;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: stimulus pushes expected writes into a scoreboard,
// a monitor pops and compares each acknowledged memory write.
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cls;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        busy;
  logic [15:0] count;
  logic        err;
  logic [1:0]  err_code;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_addr;

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .cls(cls), .funct3(funct3), .funct7b5(funct7b5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .count(count), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request; caller is 1ns after a rising edge, returns 1ns after accept.
  task automatic send(input logic [3:0] c, input logic [2:0] f3, input logic f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input bit push, input logic [31:0] exp_w);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready never rose within %0d cycles", guard);
    end else begin
      cls = c; funct3 = f3; funct7b5 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
      in_valid = 1'b1;
      if (push) begin
        sb_q.push_back({exp_addr, exp_w});
        exp_addr = exp_addr + 32'd4;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    exp_addr = 32'h0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    32'(mem_we),    32'd0);
    check({tag, "_addr"},  mem_addr,       32'h0);
    check({tag, "_wdata"}, mem_wdata,      32'h0);
    check({tag, "_count"}, 32'(count),     32'd0);
    check({tag, "_err"},   32'(err),       32'd0);
    check({tag, "_ecode"}, 32'(err_code),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  // Monitor: every acknowledged write must match the oldest expected entry.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset && mem_we && mem_ack) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", mem_addr, mem_wdata);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", mem_addr,  e[63:32]);
          check("wr_data", mem_wdata, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; cls = '0; funct3 = '0; funct7b5 = 1'b0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0; mem_ack = 1'b0; exp_addr = 32'h0;

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1 reset = 1'b1;

    // start with a simultaneous request: request must be dropped
    @(posedge clk); #1;
    start = 1'b1; cls = 4'd4; rd = 5'd1; imm = 32'd5; in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_during_start", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; exp_addr = 32'h0;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    check("no_accept_on_start", 32'(mem_we), 32'd0);

    // addi x1,x0,5
    send(4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    check("we_after_accept", 32'(mem_we), 32'd1);
    check("busy_in_write", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("count_1", 32'(count), 32'd1);
    check("we_dropped", 32'(mem_we), 32'd0);

    // back-to-back lw / sw / add / sub
    send(4'd0, 3'b010, 1'b0, 5'd2, 5'd1, 5'd0, 32'd8,  1'b1, 32'h0080_A103);
    send(4'd1, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12, 1'b1, 32'h0020_A623);
    send(4'd2, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,  1'b1, 32'h0020_81B3);
    send(4'd2, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,  1'b1, 32'h4020_81B3);
    @(posedge clk); #1;
    check("count_5", 32'(count), 32'd5);

    // control flow: beq -4, jal 8, lui
    send(4'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3);
    send(4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,         1'b1, 32'h0080_00EF);
    send(4'd7, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
    @(posedge clk); #1;
    check("count_8", 32'(count), 32'd8);

    // stall: ack low 5 cycles, extra request must wait
    mem_ack = 1'b0;
    send(4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    cls = 4'd7; rd = 5'd5; imm = 32'h1234_5000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_we",    32'(mem_we),   32'd1);
      check("stall_addr",  mem_addr,      32'h20);
      check("stall_wdata", mem_wdata,     32'h0050_0093);
      check("stall_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; mem_ack = 1'b1;
    @(posedge clk); #1;
    check("stall_addr_next", mem_addr, 32'h24);
    check("count_9", 32'(count), 32'd9);
    check("stall_we_low", 32'(mem_we), 32'd0);

    // illegal class, then misaligned branch: first code sticks
    send(4'd12, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0);
    check("err_class", 32'(err), 32'd1);
    check("ecode_class", 32'(err_code), 32'd1);
    check("err_no_write", 32'(mem_we), 32'd0);
    send(4'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd5, 1'b0, 32'h0);
    check("ecode_sticky", 32'(err_code), 32'd1);
    check("err_no_write2", 32'(mem_we), 32'd0);
    check("count_hold", 32'(count), 32'd9);

    pulse_start();
    check("start_err", 32'(err), 32'd0);
    check("start_ecode", 32'(err_code), 32'd0);
    check("start_count", 32'(count), 32'd0);
    check("start_addr", mem_addr, 32'h0);

    // jal odd and out of range: misalignment wins
    send(4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0010_0001, 1'b0, 32'h0);
    check("ecode_align", 32'(err_code), 32'd2);

    pulse_start();
    send(4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0);
    check("ecode_range", 32'(err_code), 32'd3);
    send(4'd4, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32, 1'b0, 32'h0);
    check("ecode_range_sticky", 32'(err_code), 32'd3);

    // encoding continues after an error: srai, jalr, auipc
    send(4'd4, 3'b101, 1'b1, 5'd3,  5'd1, 5'd0, 32'd4,        1'b1, 32'h4040_D193);
    send(4'd8, 3'b111, 1'b0, 5'd0,  5'd1, 5'd0, 32'd0,        1'b1, 32'h0000_8067);
    send(4'd6, 3'b000, 1'b0, 5'd10, 5'd0, 5'd0, 32'h0000_1000, 1'b1, 32'h0000_1517);
    @(posedge clk); #1;
    check("count_after_err", 32'(count), 32'd3);
    check("err_still_set", 32'(err), 32'd1);

    // reset during WRITE: strobe drops without a clock edge
    mem_ack = 1'b0;
    send(4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0);
    check("we_before_reset", 32'(mem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("we_async_drop", 32'(mem_we), 32'd0);
    @(posedge clk); #1 reset = 1'b1; mem_ack = 1'b1; exp_addr = 32'h0;
    @(negedge clk);
    check_reset_vals("post_rst");
    check("post_rst_ready", 32'(in_ready), 32'd1);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
